// File: rtl/rni_rd_alloc_if.sv
// AR-link segment in, CHI TXREQ issue, read-data completion and R-packer lookup bundle for rni_rd_alloc.
interface rni_rd_alloc_if #(
  parameter int RD_IDX_W = 3,
  parameter int ADDR_W   = 32,
  parameter int BCVEC_W  = 8,
  parameter int DMASK_W  = 16,
  parameter int SIZE_W   = 3
);
  logic                arlink_valid_s1_i;
  logic [ADDR_W-1:0]   arlink_addr_s1_i;
  logic [BCVEC_W-1:0]  arlink_bc_vec_s2_i;
  logic [DMASK_W-1:0]  arlink_dmask_s2_i;
  logic [SIZE_W-1:0]   arlink_size_s2_i;
  logic                arlink_lock_s2_i;
  logic                alloc_busy_s1_o;
  logic                txreq_valid_o;
  logic                txreq_ready_i;
  logic [RD_IDX_W-1:0] txreq_idx_o;
  logic [ADDR_W-1:0]   txreq_addr_o;
  logic [SIZE_W-1:0]   txreq_size_o;
  logic                txreq_lock_o;
  logic                rdat_done_i;
  logic [RD_IDX_W-1:0] rdat_idx_i;
  logic [RD_IDX_W-1:0] lkup_idx_i;
  logic [BCVEC_W-1:0]  lkup_bc_vec_o;
  logic [DMASK_W-1:0]  lkup_dmask_o;
  logic [RD_IDX_W:0]   outstanding_o;
  logic                err_o;

  modport master (
    output arlink_valid_s1_i, arlink_addr_s1_i, arlink_bc_vec_s2_i, arlink_dmask_s2_i,
           arlink_size_s2_i, arlink_lock_s2_i, txreq_ready_i, rdat_done_i, rdat_idx_i, lkup_idx_i,
    input  alloc_busy_s1_o, txreq_valid_o, txreq_idx_o, txreq_addr_o, txreq_size_o, txreq_lock_o,
           lkup_bc_vec_o, lkup_dmask_o, outstanding_o, err_o
  );

  modport slave (
    input  arlink_valid_s1_i, arlink_addr_s1_i, arlink_bc_vec_s2_i, arlink_dmask_s2_i,
           arlink_size_s2_i, arlink_lock_s2_i, txreq_ready_i, rdat_done_i, rdat_idx_i, lkup_idx_i,
    output alloc_busy_s1_o, txreq_valid_o, txreq_idx_o, txreq_addr_o, txreq_size_o, txreq_lock_o,
           lkup_bc_vec_o, lkup_dmask_o, outstanding_o, err_o
  );
endinterface

// File: rtl/rni_rd_alloc.sv
// Read tracker: one AR segment per cycle into the lowest free entry, issued once round-robin on TXREQ, freed on data done.
// s1 accept -> earliest txreq_valid two cycles later; busy reflects registered state only; TXREQ grant held while not ready.
module rni_rd_alloc #(
  parameter int RD_ENTRIES = 8,
  parameter int RD_IDX_W   = 3,
  parameter int ADDR_W     = 32,
  parameter int BCVEC_W    = 8,
  parameter int DMASK_W    = 16,
  parameter int SIZE_W     = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  rni_rd_alloc_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ALLOC, ST_REQ, ST_WAIT} ent_st_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [BCVEC_W-1:0] bc_vec;
    logic [DMASK_W-1:0] dmask;
    logic [SIZE_W-1:0]  size;
    logic               lock;
  } ent_t;

  ent_st_e             st_q [RD_ENTRIES];
  ent_st_e             st_d [RD_ENTRIES];
  ent_t                ent_q [RD_ENTRIES];
  logic                s2_vld_q;
  logic [RD_IDX_W-1:0] s2_idx_q;
  logic [RD_IDX_W-1:0] rr_ptr_q;
  logic                grant_lock_q;
  logic [RD_IDX_W-1:0] grant_idx_q;
  logic [RD_IDX_W:0]   outstanding_q;
  logic                err_q;

  logic [RD_ENTRIES-1:0] idle_vec;
  logic [RD_ENTRIES-1:0] req_vec;
  logic                  busy;
  logic                  accept;
  logic                  free_ok;
  logic                  hshk;
  logic                  req_any;
  logic                  grant_vld;
  logic [RD_IDX_W-1:0]   alloc_idx;
  logic [RD_IDX_W-1:0]   rr_idx;
  logic [RD_IDX_W-1:0]   cand;
  logic [RD_IDX_W-1:0]   grant_idx;

  always_comb begin
    idle_vec = '0;
    req_vec  = '0;
    for (int i = 0; i < RD_ENTRIES; i++) begin
      idle_vec[i] = (st_q[i] == ST_IDLE);
      req_vec[i]  = (st_q[i] == ST_REQ);
    end
  end

  assign busy   = ~|idle_vec;
  assign accept = bus.arlink_valid_s1_i & ~busy;

  // Downward scan so the lowest free index is the last one written.
  always_comb begin
    alloc_idx = '0;
    for (int i = RD_ENTRIES - 1; i >= 0; i--)
      if (idle_vec[i]) alloc_idx = RD_IDX_W'(i);
  end

  always_comb begin
    rr_idx  = '0;
    req_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < RD_ENTRIES; k++) begin
      cand = rr_ptr_q + RD_IDX_W'(k);
      if (!req_any && req_vec[cand]) begin
        rr_idx  = cand;
        req_any = 1'b1;
      end
    end
  end

  // A stalled grant stays REQ, so the locked index is always still valid.
  assign grant_vld = grant_lock_q | req_any;
  assign grant_idx = grant_lock_q ? grant_idx_q : rr_idx;
  assign hshk      = grant_vld & bus.txreq_ready_i;
  assign free_ok   = bus.rdat_done_i & (st_q[bus.rdat_idx_i] == ST_WAIT);

  always_comb begin
    for (int i = 0; i < RD_ENTRIES; i++) st_d[i] = st_q[i];
    if (accept)   st_d[alloc_idx]      = ST_ALLOC;
    if (s2_vld_q) st_d[s2_idx_q]       = ST_REQ;
    if (hshk)     st_d[grant_idx]      = ST_WAIT;
    if (free_ok)  st_d[bus.rdat_idx_i] = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_ENTRIES; i++) st_q[i] <= ST_IDLE;
      s2_vld_q      <= 1'b0;
      s2_idx_q      <= '0;
      rr_ptr_q      <= '0;
      grant_lock_q  <= 1'b0;
      grant_idx_q   <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      for (int i = 0; i < RD_ENTRIES; i++) st_q[i] <= st_d[i];
      s2_vld_q      <= accept;
      s2_idx_q      <= alloc_idx;
      grant_lock_q  <= grant_vld & ~bus.txreq_ready_i;
      grant_idx_q   <= grant_idx;
      if (hshk) rr_ptr_q <= grant_idx + RD_IDX_W'(1);
      outstanding_q <= outstanding_q + {{RD_IDX_W{1'b0}}, accept} - {{RD_IDX_W{1'b0}}, free_ok};
      if (bus.rdat_done_i & ~free_ok) err_q <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed once the owning entry has been written.
  always_ff @(posedge clk_i) begin
    if (accept) ent_q[alloc_idx].addr <= bus.arlink_addr_s1_i;
    if (s2_vld_q) begin
      ent_q[s2_idx_q].bc_vec <= bus.arlink_bc_vec_s2_i;
      ent_q[s2_idx_q].dmask  <= bus.arlink_dmask_s2_i;
      ent_q[s2_idx_q].size   <= bus.arlink_size_s2_i;
      ent_q[s2_idx_q].lock   <= bus.arlink_lock_s2_i;
    end
  end

  assign bus.alloc_busy_s1_o = busy;
  assign bus.txreq_valid_o   = grant_vld;
  assign bus.txreq_idx_o     = grant_vld ? grant_idx : '0;
  assign bus.txreq_addr_o    = grant_vld ? ent_q[grant_idx].addr : '0;
  assign bus.txreq_size_o    = grant_vld ? ent_q[grant_idx].size : '0;
  assign bus.txreq_lock_o    = grant_vld & ent_q[grant_idx].lock;
  assign bus.lkup_bc_vec_o   = ent_q[bus.lkup_idx_i].bc_vec;
  assign bus.lkup_dmask_o    = ent_q[bus.lkup_idx_i].dmask;
  assign bus.outstanding_o   = outstanding_q;
  assign bus.err_o           = err_q;
endmodule
